led_scan_ctrl: RTL and testbench
================================

# led_scan_ctrl

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. It holds a double-buffered bank of 5-bit digit codes written by the host logic and drives one digit at a time. For each digit it presents that digit's code to the 5-bit seven-segment decoder and asserts the matching active-low anode select. New display contents take effect only at a frame boundary, so the display never shows a torn frame.

## Interface
- NUM_DIG, 8, number of digits scanned; legal range 1..8.
- DIV_CNT, 50000, clk cycles each digit slot is lit; must be ≥2.
- BLANK_CYC, 16, dark cycles inserted between slots; used only when LED_SCAN_GHOST_BLANK_EN is defined; must be ≥1.

- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- wr_valid  in  1  host write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  3  digit index, 0 = rightmost (anode bit 0).
- wr_data  in  5  digit code: bit4 = decimal point, bits3:0 = hex value.
- swap_req  in  1  single-cycle pulse; commits the shadow bank at the next frame end.
- digit_en  in  NUM_DIG  per-digit enable mask, sampled at the start of each slot.
- dig_ctrl  out  5  code presented to the decoder.
- dec_rst_n  out  1  decoder enable; 0 forces all segments dark.
- o_an  out  NUM_DIG  active-low anode selects.
- frame_done  out  1  one-cycle pulse after the last slot of each frame.

## Operation
- Storage: two banks of NUM_DIG×5 bits, shadow and active. Both reset to 5'h00.
- Writes:
  - An accepted write stores wr_data into shadow[wr_addr].
  - A write with wr_addr ≥ NUM_DIG completes the handshake but is discarded.
- Swap:
  - swap_req sets swap_pend. swap_req while swap_pend=1 is ignored.
  - wr_ready = !swap_pend, so the shadow bank is frozen until it is copied.
  - wr_valid and swap_req in the same cycle with wr_ready=1: the write is accepted first, then swap_pend sets.
- Frame end:
  - On the cycle the last slot (idx = NUM_DIG-1) ends, frame_done=1.
  - If swap_pend=1, all of shadow is copied to active in that same cycle and swap_pend clears. wr_ready is 1 in the following cycle.
- FSM states: SCAN and BLANK. BLANK exists only with the macro.
  - SCAN, digit idx lit with digit_en[idx]=1: o_an = ~(1<<idx), dig_ctrl = active[idx], dec_rst_n = 1.
  - SCAN, digit idx with digit_en[idx]=0: o_an all 1, dec_rst_n = 0, dig_ctrl = active[idx]. The slot still lasts DIV_CNT cycles, so the refresh rate stays constant.
  - SCAN, end of slot: the slot counter reaches DIV_CNT-1. Then go to BLANK (macro) or straight to the next idx in SCAN.
  - BLANK: o_an all 1, dec_rst_n = 0, dig_ctrl holds its value. Lasts BLANK_CYC cycles, then returns to SCAN with the next idx.
  - idx wraps NUM_DIG-1 → 0.
- Counters: the slot counter is $clog2(DIV_CNT) bits, the blank counter is $clog2(BLANK_CYC+1) bits. Both clear at each state entry.
- Reset mid-frame: everything is reinitialised. Pending swaps and both banks are lost.

## Timing
- All outputs are registered.
- While rst_n=0 (sampled): o_an all 1, dec_rst_n=0, dig_ctrl=5'h00, frame_done=0, wr_ready=0, idx=0, swap_pend=0.
- First edge with rst_n=1: SCAN idx 0 starts. Outputs reflect digit 0 one cycle later, and wr_ready=1.
- A write takes effect in shadow one cycle after acceptance. It is visible on dig_ctrl no earlier than the slot after the next frame_done that follows a swap.
- Frame period:
  - Without the macro: NUM_DIG×DIV_CNT cycles.
  - With the macro: NUM_DIG×(DIV_CNT+BLANK_CYC) cycles.
- digit_en changes mid-slot are ignored until the next slot starts.

## Configuration
- LED_SCAN_GHOST_BLANK_EN defined: the BLANK state is compiled in. BLANK_CYC dark cycles are inserted after every slot to suppress ghosting.
- Not defined: there is no BLANK state and BLANK_CYC is unused. Slots are back-to-back, and o_an switches directly from one digit to the next at the slot edge.

## Test plan
Bench parameters for all scenarios: NUM_DIG=8, DIV_CNT=4, BLANK_CYC=2.
- Reset, then run 3 frames with no macro, digit_en=8'hFF:
  - o_an steps FE, FD, … 7F, each for 4 cycles, with dig_ctrl=00 throughout.
  - frame_done pulses every 32 cycles.
- Write addr3=5'h1A and addr0=5'h07, then pulse swap_req mid-frame:
  - wr_ready is 0 from the cycle after swap_req until the cycle after frame_done.
  - In the next frame, slot 0 shows dig_ctrl=07 and slot 3 shows 1A.
- Write with wr_valid held while swap is pending:
  - No acceptance until swap_pend clears.
  - The data lands in shadow only and is not displayed before the next swap.
- digit_en=8'b1111_0111:
  - During slot 3, o_an=FF and dec_rst_n=0 for 4 cycles.
  - Slot timing is unchanged.
- With LED_SCAN_GHOST_BLANK_EN:
  - Each lit slot is followed by 2 cycles with o_an=FF and dec_rst_n=0.
  - frame_done period is 48 cycles.
- rst_n pulled low mid-frame for 1 cycle with swap pending:
  - Next cycle: all outputs at reset values and swap_pend=0.
  - Scan restarts at idx 0 with both banks at 00.

Source files
------------

// File: rtl/led_scan_ctrl_if.sv
// Host write/swap port of the seven-segment scan controller.
//
// Signals:
//   wr_valid  host write request
//   wr_ready  controller can accept a write (low while a bank swap is pending)
//   wr_addr   digit index, 0 = rightmost digit
//   wr_data   digit code: bit4 = decimal point, bits3:0 = hex value
//   swap_req  single-cycle pulse asking for the shadow bank to go live at frame end
//
// Modports: master = host logic, slave = led_scan_ctrl.
interface led_scan_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic       swap_req;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output swap_req,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  swap_req,
    output wr_ready
  );
endinterface

// File: rtl/led_scan_ctrl.sv
// Time-multiplexed scan controller for an up-to-8-digit common-anode
// seven-segment display. Host writes land in a shadow bank; a swap request
// copies the shadow bank into the active bank at the next frame end, so a
// frame is never torn. One digit is driven at a time.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   wr_if       host write/swap port (led_scan_ctrl_if.slave)
//   digit_en    per-digit enable mask, sampled at the start of each slot
//   dig_ctrl    5-bit code for the segment decoder
//   dec_rst_n   decoder enable, 0 forces all segments dark
//   o_an        active-low anode selects
//   frame_done  one-cycle pulse during the last cycle of the last slot
//
// Build option: define LED_SCAN_GHOST_BLANK_EN to insert BLANK_CYC dark
// cycles after every slot (anti-ghosting). Without it slots are back-to-back.
//
// All outputs are registered from the next-state values, so the output
// registers always describe the cycle the FSM is currently in.
module led_scan_ctrl #(
  parameter int unsigned NUM_DIG   = 8,
  parameter int unsigned DIV_CNT   = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  led_scan_ctrl_if.slave     wr_if,
  input  logic [NUM_DIG-1:0] digit_en,
  output logic [4:0]         dig_ctrl,
  output logic               dec_rst_n,
  output logic [NUM_DIG-1:0] o_an,
  output logic               frame_done
);

  localparam int unsigned        CW          = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam logic [CW-1:0]      SLOT_LAST_C = CW'(DIV_CNT - 1);
  localparam logic [CW-1:0]      CNT_ONE_C   = CW'(1'b1);
  localparam logic [CW-1:0]      CNT_ZERO_C  = CW'(1'b0);
  localparam logic [2:0]         IDX_LAST_C  = 3'(NUM_DIG - 1);
  localparam logic [NUM_DIG-1:0] AN_OFF_C    = {NUM_DIG{1'b1}};
  localparam logic [NUM_DIG-1:0] AN_BIT0_C   = NUM_DIG'(1'b1);
  // An out-of-range parameter set keeps every anode off.
  localparam bit CFG_OK_C = (NUM_DIG >= 1) && (NUM_DIG <= 8) &&
                            (DIV_CNT >= 2) && (BLANK_CYC >= 1);

`ifdef LED_SCAN_GHOST_BLANK_EN
  localparam int unsigned   BW            = $clog2(BLANK_CYC + 1);
  localparam logic [BW-1:0] BLANK_LAST_C  = BW'(BLANK_CYC - 1);
  localparam logic [BW-1:0] BLANK_ONE_C   = BW'(1'b1);
  localparam logic [BW-1:0] BLANK_ZERO_C  = BW'(1'b0);
  typedef enum logic [0:0] {SCAN = 1'b0, BLANK = 1'b1} state_t;
`else
  typedef enum logic [0:0] {SCAN = 1'b0} state_t;
`endif

  state_t                   state_r, state_nxt_s;
  logic [2:0]               idx_r, idx_nxt_s, idx_inc_s;
  logic [CW-1:0]            cnt_r, cnt_nxt_s;
`ifdef LED_SCAN_GHOST_BLANK_EN
  logic [BW-1:0]            blank_cnt_r, blank_cnt_nxt_s;
`endif
  logic                     start_r;
  logic                     en_r, en_nxt_s;
  logic                     slot_start_s;
  logic                     end_s;
  logic                     wr_acc_s;
  logic                     swap_pend_r, swap_pend_nxt_s;
  logic [NUM_DIG-1:0][4:0]  shadow_r, shadow_nxt_s;
  logic [NUM_DIG-1:0][4:0]  active_r, active_nxt_s;
  logic                     lit_s;
  logic                     wr_ready_r;
  logic [4:0]               dig_ctrl_r, dig_nxt_s;
  logic                     dec_rst_n_r;
  logic [NUM_DIG-1:0]       o_an_r, an_nxt_s;
  logic                     frame_done_r, fd_nxt_s;

  // Next-state, bank/swap bookkeeping and next-output decode.
  always_comb begin
    state_nxt_s     = state_r;
    idx_nxt_s       = idx_r;
    cnt_nxt_s       = cnt_r;
`ifdef LED_SCAN_GHOST_BLANK_EN
    blank_cnt_nxt_s = blank_cnt_r;
`endif
    slot_start_s    = 1'b0;
    end_s           = 1'b0;
    idx_inc_s       = (idx_r == IDX_LAST_C) ? 3'd0 : (idx_r + 3'd1);

    if (!start_r) begin
      // First cycle out of reset opens slot 0.
      state_nxt_s  = SCAN;
      idx_nxt_s    = 3'd0;
      cnt_nxt_s    = CNT_ZERO_C;
      slot_start_s = 1'b1;
    end else begin
      case (state_r)
        SCAN: begin
          if (cnt_r == SLOT_LAST_C) begin
            end_s = (idx_r == IDX_LAST_C);
`ifdef LED_SCAN_GHOST_BLANK_EN
            state_nxt_s     = BLANK;
            blank_cnt_nxt_s = BLANK_ZERO_C;
`else
            idx_nxt_s    = idx_inc_s;
            cnt_nxt_s    = CNT_ZERO_C;
            slot_start_s = 1'b1;
`endif
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE_C;
          end
        end
`ifdef LED_SCAN_GHOST_BLANK_EN
        BLANK: begin
          if (blank_cnt_r == BLANK_LAST_C) begin
            state_nxt_s  = SCAN;
            idx_nxt_s    = idx_inc_s;
            cnt_nxt_s    = CNT_ZERO_C;
            slot_start_s = 1'b1;
          end else begin
            blank_cnt_nxt_s = blank_cnt_r + BLANK_ONE_C;
          end
        end
`endif
        default: begin
          state_nxt_s  = SCAN;
          idx_nxt_s    = 3'd0;
          cnt_nxt_s    = CNT_ZERO_C;
          slot_start_s = 1'b1;
        end
      endcase
    end

    // The enable bit is frozen for the whole slot.
    if (slot_start_s) begin
      en_nxt_s = digit_en[idx_nxt_s];
    end else begin
      en_nxt_s = en_r;
    end

    // Writes to digits beyond NUM_DIG complete the handshake but are dropped.
    wr_acc_s     = wr_if.wr_valid && wr_ready_r;
    shadow_nxt_s = shadow_r;
    if (wr_acc_s && ({1'b0, wr_if.wr_addr} < 4'(NUM_DIG))) begin
      shadow_nxt_s[wr_if.wr_addr] = wr_if.wr_data;
    end else begin
      shadow_nxt_s = shadow_r;
    end

    // A pending swap commits on the frame-end cycle; new requests are
    // ignored while one is already pending.
    active_nxt_s = active_r;
    if (end_s && swap_pend_r) begin
      active_nxt_s    = shadow_r;
      swap_pend_nxt_s = 1'b0;
    end else if (wr_if.swap_req && !swap_pend_r) begin
      swap_pend_nxt_s = 1'b1;
    end else begin
      swap_pend_nxt_s = swap_pend_r;
    end

    // Decode outputs for the cycle being entered; dig_ctrl uses the
    // post-swap bank so the first cycle of a new frame already shows it.
    lit_s     = CFG_OK_C && (state_nxt_s == SCAN) && en_nxt_s;
    an_nxt_s  = lit_s ? ~(AN_BIT0_C << idx_nxt_s) : AN_OFF_C;
    dig_nxt_s = (state_nxt_s == SCAN) ? active_nxt_s[idx_nxt_s] : dig_ctrl_r;
    fd_nxt_s  = (state_nxt_s == SCAN) && (idx_nxt_s == IDX_LAST_C) &&
                (cnt_nxt_s == SLOT_LAST_C);
  end

  // State, banks and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_r      <= 1'b0;
      state_r      <= SCAN;
      idx_r        <= 3'd0;
      cnt_r        <= CNT_ZERO_C;
`ifdef LED_SCAN_GHOST_BLANK_EN
      blank_cnt_r  <= BLANK_ZERO_C;
`endif
      en_r         <= 1'b0;
      swap_pend_r  <= 1'b0;
      shadow_r     <= {NUM_DIG{5'h00}};
      active_r     <= {NUM_DIG{5'h00}};
      wr_ready_r   <= 1'b0;
      dig_ctrl_r   <= 5'h00;
      dec_rst_n_r  <= 1'b0;
      o_an_r       <= AN_OFF_C;
      frame_done_r <= 1'b0;
    end else begin
      start_r      <= 1'b1;
      state_r      <= state_nxt_s;
      idx_r        <= idx_nxt_s;
      cnt_r        <= cnt_nxt_s;
`ifdef LED_SCAN_GHOST_BLANK_EN
      blank_cnt_r  <= blank_cnt_nxt_s;
`endif
      en_r         <= en_nxt_s;
      swap_pend_r  <= swap_pend_nxt_s;
      shadow_r     <= shadow_nxt_s;
      active_r     <= active_nxt_s;
      wr_ready_r   <= !swap_pend_nxt_s;
      dig_ctrl_r   <= dig_nxt_s;
      dec_rst_n_r  <= lit_s;
      o_an_r       <= an_nxt_s;
      frame_done_r <= fd_nxt_s;
    end
  end

  assign wr_if.wr_ready = wr_ready_r;
  assign dig_ctrl       = dig_ctrl_r;
  assign dec_rst_n      = dec_rst_n_r;
  assign o_an           = o_an_r;
  assign frame_done     = frame_done_r;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl. A time-indexed reference model
// (slot = cycle / slot period, phase = cycle % slot period) predicts every
// output each cycle; directed phases follow the scenarios of interest and a
// randomized phase mixes writes, swaps and enable changes.
`timescale 1ns/1ps
module tb_led_scan_ctrl;
  localparam int NUM_DIG   = 8;
  localparam int DIV_CNT   = 4;
  localparam int BLANK_CYC = 2;
`ifdef LED_SCAN_GHOST_BLANK_EN
  localparam int GAP = BLANK_CYC;
`else
  localparam int GAP = 0;
`endif
  localparam int SLOT_P  = DIV_CNT + GAP;
  localparam int FRAME_P = NUM_DIG * SLOT_P;
  localparam int END_PH  = FRAME_P - GAP - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] digit_en;
  logic [4:0] dig_ctrl;
  logic       dec_rst_n;
  logic [7:0] o_an;
  logic       frame_done;

  led_scan_ctrl_if bus ();

  led_scan_ctrl #(
    .NUM_DIG  (NUM_DIG),
    .DIV_CNT  (DIV_CNT),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_if     (bus),
    .digit_en  (digit_en),
    .dig_ctrl  (dig_ctrl),
    .dec_rst_n (dec_rst_n),
    .o_an      (o_an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int         m_t = -1;
  int         last_fd = -1;
  logic [4:0] m_shadow [NUM_DIG];
  logic [4:0] m_active [NUM_DIG];
  bit         m_pend;
  bit   [7:0] m_en;
  logic [7:0] exp_an    = 8'hFF;
  logic       exp_dec   = 1'b0;
  logic [4:0] exp_dig   = 5'h00;
  logic       exp_fd    = 1'b0;
  logic       exp_ready = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, m_t);
    end
  endtask

  // Advance the model over one clock edge using the inputs present at it.
  task automatic model_edge();
    bit was_end;
    int s;
    int ph;
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        m_shadow[i] = 5'h00;
        m_active[i] = 5'h00;
      end
      m_pend    = 1'b0;
      m_en      = 8'h00;
      m_t       = -1;
      last_fd   = -1;
      exp_an    = 8'hFF;
      exp_dec   = 1'b0;
      exp_dig   = 5'h00;
      exp_fd    = 1'b0;
      exp_ready = 1'b0;
    end else begin
      was_end = (m_t >= 0) && ((m_t % FRAME_P) == END_PH);
      if (bus.wr_valid && exp_ready && (int'(bus.wr_addr) < NUM_DIG))
        m_shadow[bus.wr_addr] = bus.wr_data;
      if (was_end && m_pend) begin
        for (int i = 0; i < NUM_DIG; i++) m_active[i] = m_shadow[i];
        m_pend = 1'b0;
      end else if (bus.swap_req && !m_pend) begin
        m_pend = 1'b1;
      end
      m_t++;
      s  = (m_t / SLOT_P) % NUM_DIG;
      ph = m_t % SLOT_P;
      if (ph == 0) m_en[s] = digit_en[s];
      if (ph < DIV_CNT) begin
        exp_dig = m_active[s];
        exp_dec = m_en[s];
        exp_an  = m_en[s] ? ~(8'h01 << s) : 8'hFF;
      end else begin
        exp_dec = 1'b0;
        exp_an  = 8'hFF;
      end
      exp_fd    = ((m_t % FRAME_P) == END_PH);
      exp_ready = !m_pend;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_val("o_an", o_an, exp_an);
    check_val("dec_rst_n", dec_rst_n, exp_dec);
    check_val("dig_ctrl", dig_ctrl, exp_dig);
    check_val("frame_done", frame_done, exp_fd);
    check_val("wr_ready", bus.wr_ready, exp_ready);
    if (frame_done) begin
      if (last_fd >= 0) check_val("fd_period", m_t - last_fd, FRAME_P);
      last_fd = m_t;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold a write until the model says it was accepted (bounded).
  task automatic host_write(input logic [2:0] a, input logic [4:0] d);
    bit done;
    done = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    for (int i = 0; i < 4 * FRAME_P && !done; i++) begin
      done = exp_ready;
      step();
    end
    bus.wr_valid = 1'b0;
    check_val("wr_accept", done, 1'b1);
  endtask

  task automatic pulse_swap();
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    digit_en     = 8'hFF;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = 3'd0;
    bus.wr_data  = 5'h00;
    bus.swap_req = 1'b0;

    // Reset, then three idle frames.
    run(3);
    rst_n = 1'b1;
    run(3 * FRAME_P);

    // Two writes, swap mid-frame, watch the new contents appear.
    host_write(3'd3, 5'h1A);
    host_write(3'd0, 5'h07);
    run(7);
    pulse_swap();
    run(2 * FRAME_P);

    // Write held while a swap is pending; data must stay in shadow only.
    pulse_swap();
    host_write(3'd5, 5'h15);
    run(FRAME_P + 5);
    pulse_swap();
    run(2 * FRAME_P);

    // Digit 3 disabled.
    digit_en = 8'b1111_0111;
    run(2 * FRAME_P);
    digit_en = 8'hFF;
    run(FRAME_P);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_addr  = 3'($urandom_range(0, 7));
      bus.wr_data  = 5'($urandom_range(0, 31));
      bus.swap_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) digit_en = 8'($urandom_range(0, 255));
      step();
    end
    bus.wr_valid = 1'b0;
    bus.swap_req = 1'b0;
    digit_en     = 8'hFF;

    // Mid-frame reset with a swap pending.
    host_write(3'd2, 5'h0C);
    pulse_swap();
    run(5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(2 * FRAME_P);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
